// File: rtl/oc_15input.sv
// Registered 15-input ones counter built from a full-adder compression tree.
// Optional all_ones flag output and register are compiled only when OC_ALL_ONES_EN is defined.
module oc_15input (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   input  logic e,
   input  logic f,
   input  logic g,
   input  logic h,
   input  logic i,
   input  logic j,
   input  logic k,
   input  logic l,
   input  logic m,
   input  logic n,
   input  logic o,
   output logic y0,
   output logic y1,
   output logic y2,
   output logic y3
`ifdef OC_ALL_ONES_EN
   ,
   output logic all_ones
`endif
);

   // Returns {carry, sum} for three equal-weight bits.
   function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
      return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
   endfunction

   logic [1:0] w_fa0, w_fa1, w_fa2, w_fa3, w_fa4;
   logic [1:0] w_fa5, w_fa6, w_fa7, w_fa8, w_fa9, w_fa10;
   logic [3:0] w_sum;
   logic [3:0] r_cnt;

   assign w_fa0 = fa(a, b, c);
   assign w_fa1 = fa(d, e, f);
   assign w_fa2 = fa(g, h, i);
   assign w_fa3 = fa(j, k, l);
   assign w_fa4 = fa(m, n, o);

   // Weight-1 column: five sums reduce to bit 0, carries move to weight 2.
   assign w_fa5 = fa(w_fa0[0], w_fa1[0], w_fa2[0]);
   assign w_fa6 = fa(w_fa3[0], w_fa4[0], w_fa5[0]);

   // Weight-2 column holds seven bits: five first-level carries plus two.
   assign w_fa7 = fa(w_fa0[1], w_fa1[1], w_fa2[1]);
   assign w_fa8 = fa(w_fa3[1], w_fa4[1], w_fa5[1]);
   assign w_fa9 = fa(w_fa7[0], w_fa8[0], w_fa6[1]);

   // Weight-4 column holds three bits; its carry is the MSB.
   assign w_fa10 = fa(w_fa7[1], w_fa8[1], w_fa9[1]);

   assign w_sum = {w_fa10[1], w_fa10[0], w_fa9[0], w_fa6[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= 4'd0;
      else if (en)
         r_cnt <= w_sum;
   end

   assign y0 = r_cnt[0];
   assign y1 = r_cnt[1];
   assign y2 = r_cnt[2];
   assign y3 = r_cnt[3];

`ifdef OC_ALL_ONES_EN
   logic r_all_ones;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_all_ones <= 1'b0;
      else if (en)
         r_all_ones <= (w_sum == 4'd15);
   end

   assign all_ones = r_all_ones;
`endif

endmodule

// File: tb/tb_oc_15input.sv
// Self-checking bench for oc_15input: directed scenarios plus random vectors against a popcount model.
// Checks all_ones as well when built with OC_ALL_ONES_EN.
module tb_oc_15input;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic [14:0] v = '0;
   logic        y0, y1, y2, y3;
   int          n_tests = 0;
   int          n_fail = 0;
   int          exp_cnt = 0;
`ifdef OC_ALL_ONES_EN
   logic        all_ones;
`endif

   always #5 clk = ~clk;

   oc_15input dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .a(v[0]), .b(v[1]), .c(v[2]), .d(v[3]), .e(v[4]),
      .f(v[5]), .g(v[6]), .h(v[7]), .i(v[8]), .j(v[9]),
      .k(v[10]), .l(v[11]), .m(v[12]), .n(v[13]), .o(v[14]),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3)
`ifdef OC_ALL_ONES_EN
      , .all_ones(all_ones)
`endif
   );

   function automatic int ones_of(input logic [14:0] x);
      int s = 0;
      for (int q = 0; q < 15; q++)
         if (x[q]) s++;
      return s;
   endfunction

   task automatic chk(input string tag, input int expv);
      int got;
      got = int'({y3, y2, y1, y0});
      n_tests++;
      assert (got === expv)
      else begin
         n_fail++;
         $error("FAIL %s: count got %0d expected %0d", tag, got, expv);
      end
`ifdef OC_ALL_ONES_EN
      n_tests++;
      assert (all_ones === (expv == 15))
      else begin
         n_fail++;
         $error("FAIL %s all_ones: got %0b expected %0b", tag, all_ones, (expv == 15));
      end
`endif
   endtask

   // Drive on the falling edge, advance the model at the rising edge, sample 1ns later.
   task automatic step(input logic [14:0] vec, input logic en_v);
      @(negedge clk);
      v  = vec;
      en = en_v;
      @(posedge clk);
      if (rst_n && en_v) exp_cnt = ones_of(vec);
      #1;
   endtask

   initial begin
      logic [14:0] rv;
      logic        re;

      // Async reset with every input high and en asserted, before any clock edge.
      v  = '1;
      en = 1'b1;
      #2 rst_n = 1'b0;
      exp_cnt = 0;
      #1 chk("reset_async", 0);
      step('1, 1'b1);
      chk("reset_hold1", 0);
      step('1, 1'b1);
      chk("reset_hold2", 0);
      @(negedge clk);
      v = '0;
      rst_n = 1'b1;

      // Incremental ones: a, then o, then m.
      step(15'h0000, 1'b1);                     chk("incr_zero", 0);
      step(15'h0001, 1'b1);                     chk("incr_a", 1);
      step(15'h4001, 1'b1);                     chk("incr_ao", 2);
      step(15'h5001, 1'b1);                     chk("incr_aom", 3);

      // Enable hold: b..l raised while en is low, count must stay at 3.
      step(15'h5FFF, 1'b0);                     chk("hold1", 3);
      step(15'h5FFF, 1'b0);                     chk("hold2", 3);
      step(15'h5FFF, 1'b0);                     chk("hold3", 3);
      step(15'h5FFF, 1'b1);                     chk("hold_release", 14);

      // Extremes.
      step('1, 1'b1);                           chk("all_ones", 15);
      step('0, 1'b1);                           chk("all_zero", 0);
      step('1, 1'b1);                           chk("all_ones_again", 15);
      step(15'h7FFE, 1'b1);                     chk("fourteen", 14);

      // Mid-operation reset from a count of 10.
      step(15'h03FF, 1'b1);                     chk("pre_reset_10", 10);
      #2 rst_n = 1'b0;
      exp_cnt = 0;
      #1 chk("mid_reset_async", 0);
      step(15'h7FFF, 1'b1);                     chk("mid_reset_held", 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("after_release_no_edge", 0);
      step(15'h0155, 1'b1);                     chk("first_edge_after_release", 5);

      // Random vectors, en mostly high.
      for (int t = 0; t < 12000; t++) begin
         rv = 15'($urandom);
         re = ($urandom_range(0, 9) != 0);
         step(rv, re);
         chk("random", exp_cnt);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/oc_15input.md
OC_15INPUT -- requirements
Module: oc_15input

Interface
REQ-001 SHALL provide port: clk  input  1  single system clock, rising-edge active.
REQ-002 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide port: en  input  1  sample enable; count register loads only when en=1.
REQ-004 SHALL provide ports: a, b, c, d, e, f, g, h, i, j, k, l, m, n, o  input  1 each  the 15 data bits to be counted, equal weight, no ordering significance.
REQ-005 SHALL provide ports: y0, y1, y2, y3  output  1 each  registered 4-bit ones count, y0 = LSB (weight 1), y3 = MSB (weight 8).
REQ-006 SHALL provide port (only with OC_ALL_ONES_EN): all_ones  output  1  registered flag, high when the registered count equals 15.
REQ-007 SHALL use one clock domain (clk); reset is asynchronous and active-low (rst_n).

Function
REQ-008 SHALL compute the population count of {a..o}: the number of inputs equal to 1, range 0..15, unsigned.
REQ-009 SHALL represent the count exactly in {y3,y2,y1,y0}; 15 ones -> 4'b1111; no overflow or saturation is possible.
REQ-010 SHALL register the count: on a rising clk edge with en=1, {y3..y0} takes the popcount of the inputs sampled at that edge (latency 1 cycle).
REQ-011 SHALL hold {y3..y0} (and all_ones) unchanged on any rising clk edge with en=0.
REQ-012 SHALL build the popcount from a full-adder/half-adder compression tree (15 single-bit inputs -> 4-bit sum), purely combinational ahead of the output register; no multi-cycle iteration.
REQ-013 SHALL drive outputs only from flip-flops; no combinational path from a..o or en to any output.
REQ-014 SHALL treat X/Z-free inputs only; behaviour with unknown inputs is unspecified.
REQ-015 SHALL give the result for simultaneous multi-bit changes the same as the final input vector (no dependence on change order).

Reset
REQ-016 SHALL force y0..y3 = 0 (and all_ones = 0 when present) immediately when rst_n falls, independent of clk.
REQ-017 SHALL hold outputs at 0 while rst_n=0, regardless of en and data inputs.
REQ-018 SHALL resume normal loading on the first rising clk edge after rst_n rises; reset asserted mid-operation discards the held count.

Configuration
REQ-019 SHALL compile the all_ones output and its register only when the macro OC_ALL_ONES_EN is defined.
REQ-020 With OC_ALL_ONES_EN defined, all_ones SHALL load (en=1) as (popcount == 15), with the same timing and reset as y0..y3.
REQ-021 Without OC_ALL_ONES_EN, the port SHALL be absent and y0..y3 behaviour SHALL be identical.

Verification
REQ-022 Reset: rst_n=0 with all inputs 1 and en=1 -> y3..y0 = 0000 asynchronously (no clk edge needed), all_ones=0.
REQ-023 Incremental: rst_n=1, en=1, all inputs 0 -> 0000; set a=1 -> 0001 after next edge; then o=1 -> 0010; then m=1 -> 0011.
REQ-024 Extremes: all 15 inputs 1 -> 1111 one cycle later, all_ones=1 (macro on); then all 0 -> 0000, all_ones=0.
REQ-025 Enable hold: count at 0011, en=0, set b..l=1 -> outputs stay 0011 for several edges; en=1 -> 1110 after next edge.
REQ-026 Exhaustive/random: 2^15 input vectors (or >=10000 random) with en=1 -> each output equals popcount of the vector sampled one edge earlier.
REQ-027 Mid-operation reset: count 1010, pulse rst_n low between edges -> outputs 0000 immediately and remain 0 until the first edge after release.
